reg_file_mp: RTL and testbench



---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_rd_mux.sv | 24 ++
 rtl/reg_file_mp.sv | 125 ++++++++++++
 tb/tb_reg_file_mp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants, clear-FSM encoding and port slicing helper for reg_file_mp
package reg_file_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RF_WIDTH  = 32;
  localparam int RF_SIZE   = 5;
  localparam int RF_NUM_RD = 2;

  // LSB position of element idx within a packed vector of w-bit elements
  function automatic int port_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/reg_file_rd_mux.sv
// rtl/reg_file_rd_mux.sv - DEPTH:1 combinational read selector over a flattened register array
module reg_file_rd_mux
  import reg_file_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int SIZE  = RF_SIZE
) (
  input  logic [(WIDTH << SIZE)-1:0] regs_flat,
  input  logic [SIZE-1:0]            addr,
  output logic [WIDTH-1:0]           data
);

  localparam int DEPTH = 1 << SIZE;

  always_comb begin
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (addr == SIZE'(k)) begin
        data = regs_flat[port_lsb(k, WIDTH) +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with bypass, zero register and sequenced bulk clear
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int SIZE     = RF_SIZE,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [SIZE-1:0]         wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*SIZE-1:0]  rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int DEPTH = 1 << SIZE;

  logic [WIDTH-1:0]         regs [DEPTH];
  logic [DEPTH*WIDTH-1:0]   regs_flat;
  clr_state_e               state_q, state_d;
  logic [SIZE-1:0]          cnt_q, cnt_d;
  logic                     wr_zero;

  assign busy    = (state_q == ST_CLEAR);
  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The sweep owns the array while busy; host writes are dropped, not queued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else if (busy) begin
      regs[cnt_q] <= '0;
    end else if (wr_en && !wr_zero) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      regs_flat[port_lsb(k, WIDTH) +: WIDTH] = regs[k];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [SIZE-1:0]  addr;
    logic [WIDTH-1:0] mux_data;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             zero_hit;
    logic             byp_hit;

    assign addr = rd_addr[port_lsb(i, SIZE) +: SIZE];

    reg_file_rd_mux #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE)
    ) u_mux (
      .regs_flat (regs_flat),
      .addr      (addr),
      .data      (mux_data)
    );

    assign zero_hit = (ZERO_REG != 0) && (addr == '0);
    assign byp_hit  = (BYPASS != 0) && !busy && wr_en && (wr_addr == addr);

    // Zero register wins over bypass so a dropped write to r0 never leaks out
    always_comb begin
      sel_data = mux_data;
      if (zero_hit)     sel_data = '0;
      else if (byp_hit) sel_data = wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[i];
        if (rd_en[i]) data_q <= sel_data;
      end
    end

    assign rd_data[port_lsb(i, WIDTH) +: WIDTH] = data_q;
    assign rd_valid[i] = valid_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp (bypass and no-bypass instances)
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        clr_req;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_valid, rd_valid_nb;
  logic        busy, busy_nb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(32), .SIZE(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .busy(busy)
  );

  reg_file_mp #(.WIDTH(32), .SIZE(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_valid(rd_valid_nb),
    .clr_req(clr_req), .busy(busy_nb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 2'b00;
    clr_req = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    idle();
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    logic [63:0] acc;

    reset = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle();
    tick();
    check("reset_rd_data", rd_data, 64'h0);
    check("reset_rd_valid", {62'h0, rd_valid}, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    reset = 1'b1;

    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    tick();
    check("post_reset_read", rd_data[31:0], 64'h0);
    check("post_reset_valid", {62'h0, rd_valid}, 64'h1);

    // write then dual-port read of the same register
    write(5'd5, 32'hDEADBEEF);
    rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    tick();
    check("rd_port0", rd_data[31:0], 64'hDEADBEEF);
    check("rd_port1", rd_data[63:32], 64'hDEADBEEF);
    check("rd_valid_pulse", {62'h0, rd_valid}, 64'h3);
    idle();
    tick();
    check("rd_valid_drop", {62'h0, rd_valid}, 64'h0);
    check("rd_data_hold", rd_data[31:0], 64'hDEADBEEF);

    // same-cycle write/read: forwarded vs pre-write value
    write(5'd7, 32'h11);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    check("bypass_on", rd_data[31:0], 64'h22);
    check("bypass_off", rd_data_nb[31:0], 64'h11);
    idle();
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    tick();
    check("after_bypass_nb", rd_data_nb[63:32], 64'h22);

    // hardwired zero register, including a same-cycle write to r0
    write(5'd0, 32'hFFFFFFFF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    tick();
    check("zero_reg_bypass", rd_data, 64'h0);
    check("zero_reg_nb", rd_data_nb, 64'h0);

    // asynchronous reset with no clock edge
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    check("pre_async_rd", rd_data[31:0], 64'hDEADBEEF);
    #2 reset = 1'b0;
    #1;
    check("async_rd_data", rd_data, 64'h0);
    check("async_rd_valid", {62'h0, rd_valid}, 64'h0);
    reset = 1'b1;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    check("async_reg_cleared", rd_data[31:0], 64'h0);

    // bulk clear over r1..r31 holding their own index
    for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
    idle();
    check("busy_before_clr", {63'h0, busy}, 64'h0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      if (c == 0)  check("busy_rise", {63'h0, busy}, 64'h1);
      if (c == 32) check("busy_fall", {63'h0, busy}, 64'h0);
      idle();
      if (c == 5) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hABCD;
        rd_en = 2'b10; rd_addr[9:5] = 5'd3;
        clr_req = 1'b1;
      end
      if (c == 10 || c == 25) begin
        rd_en = 2'b01; rd_addr[4:0] = 5'd20;
      end
      tick();
      if (c == 5)  check("busy_no_bypass", rd_data[63:32], 64'h0);
      if (c == 10) check("sweep_r20_old", rd_data[31:0], 64'd20);
      if (c == 25) check("sweep_r20_clr", rd_data[31:0], 64'h0);
    end
    check("busy_len", 64'(busy_cnt), 64'd32);

    acc = '0;
    for (int i = 0; i < 32; i++) begin
      idle();
      rd_en = 2'b11; rd_addr = {5'(31 - i), 5'(i)};
      tick();
      acc = acc | rd_data;
    end
    check("all_cleared", acc, 64'h0);

    // reset in the middle of a sweep, then a fresh full-length sweep
    write(5'd20, 32'h77);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (12) tick();
    check("mid_clear_busy", {63'h0, busy}, 64'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    reset = 1'b1;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd20};
    tick();
    check("abort_r20_reset", rd_data[31:0], 64'h0);
    check("abort_stay_idle", {63'h0, busy}, 64'h0);

    write(5'd1, 32'h55);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      idle();
      if (c == 0 || c == 2) begin
        rd_en = 2'b01; rd_addr[4:0] = 5'd1;
      end
      tick();
      if (c == 0) check("restart_r1_old", rd_data[31:0], 64'h55);
      if (c == 2) check("restart_r1_clr", rd_data[31:0], 64'h0);
    end
    check("restart_busy_len", 64'(busy_cnt), 64'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
